// File: rtl/rca_pipe.sv
// Pipelined ripple-carry add/sub, one CHUNK-bit ripple segment per stage; latency WIDTH/CHUNK cycles, 1 op/cycle.
// Backpressure: whole pipe advances only when the output register is empty or being retired; in_ready mirrors that.
module rca_pipe #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] S,
    output logic             Cout,
    output logic             V
);

    localparam int CHUNK_SAFE = (CHUNK < 1) ? 1 : CHUNK;
    localparam int NSTAGES    = (WIDTH / CHUNK_SAFE < 1) ? 1 : WIDTH / CHUNK_SAFE;

    if ((CHUNK < 1) || (WIDTH % CHUNK_SAFE != 0)) begin : g_param_check
        $error("rca_pipe: WIDTH must be a positive multiple of CHUNK (CHUNK >= 1)");
    end

    function automatic logic [1:0] full_add(input logic a, input logic b, input logic ci);
        return {(a & b) | (ci & (a ^ b)), a ^ b ^ ci};
    endfunction

    logic                              en;
    logic [NSTAGES-1:0]                stg_vld;
    logic [NSTAGES-1:0]                stg_c;
    logic [NSTAGES-1:0]                ovf_s;
    logic [NSTAGES-1:0][WIDTH-1:0]     stg_sum;
    logic [NSTAGES-1:0][WIDTH-1:0]     stg_a;
    logic [NSTAGES-1:0][WIDTH-1:0]     stg_b;
    logic                              v_q;

    assign en       = !stg_vld[NSTAGES-1] || out_ready;
    assign in_ready = en;

    for (genvar k = 0; k < NSTAGES; k++) begin : g_stage
        localparam int LSB = k * CHUNK_SAFE;

        logic             src_vld;
        logic             src_c;
        logic [WIDTH-1:0] src_a;
        logic [WIDTH-1:0] src_b;
        logic [WIDTH-1:0] src_sum;
        logic [CHUNK_SAFE:0] cy;
        logic [WIDTH-1:0] sum_d;

        logic             vld_q;
        logic             c_q;
        logic [WIDTH-1:0] sum_q;
        logic [WIDTH-1:0] a_q;
        logic [WIDTH-1:0] b_q;

        // Subtract folds into stage 0: invert B and force the carry-in, then travels as plain add.
        if (k == 0) begin : g_head
            assign src_vld = in_valid;
            assign src_a   = A;
            assign src_b   = sub ? ~B : B;
            assign src_c   = sub | Cin;
            assign src_sum = '0;
        end else begin : g_body
            assign src_vld = stg_vld[k-1];
            assign src_a   = stg_a[k-1];
            assign src_b   = stg_b[k-1];
            assign src_c   = stg_c[k-1];
            assign src_sum = stg_sum[k-1];
        end

        always_comb begin
            cy    = '0;
            cy[0] = src_c;
            sum_d = src_sum;
            for (int i = 0; i < CHUNK_SAFE; i++) begin
                {cy[i+1], sum_d[LSB+i]} = full_add(src_a[LSB+i], src_b[LSB+i], cy[i]);
            end
        end

        assign ovf_s[k] = cy[CHUNK_SAFE] ^ cy[CHUNK_SAFE-1];

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                vld_q <= 1'b0;
                c_q   <= 1'b0;
                sum_q <= '0;
                a_q   <= '0;
                b_q   <= '0;
            end else if (en) begin
                vld_q <= src_vld;
                c_q   <= cy[CHUNK_SAFE];
                sum_q <= sum_d;
                a_q   <= src_a;
                b_q   <= src_b;
            end
        end

        assign stg_vld[k] = vld_q;
        assign stg_c[k]   = c_q;
        assign stg_sum[k] = sum_q;
        assign stg_a[k]   = a_q;
        assign stg_b[k]   = b_q;
    end

    // Only the last segment's carry pair is the MSB carry pair that defines signed overflow.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v_q <= 1'b0;
        end else if (en) begin
            v_q <= ovf_s[NSTAGES-1];
        end
    end

    assign out_valid = stg_vld[NSTAGES-1];
    assign S         = stg_sum[NSTAGES-1];
    assign Cout      = stg_c[NSTAGES-1];
    assign V         = v_q;

    logic unused_tail;
    assign unused_tail = ^{stg_a[NSTAGES-1], stg_b[NSTAGES-1], ovf_s};

endmodule

// File: doc/rca_pipe.md
# rca_pipe

Parametrised, pipelined ripple-carry adder/subtractor built from chained 1-bit full-adder cells, organised as CHUNK-bit ripple segments separated by pipeline registers. It generalises the team's fixed 4-bit combinational ripple adder to arbitrary WIDTH, adds a subtract mode and a signed-overflow flag, and carries operands through a valid/ready stream interface with backpressure. It sits in datapaths that need wide adds at high clock rate, accepting one operation per cycle.

## Interface
- WIDTH, 16, operand/result width in bits; must be a multiple of CHUNK
- CHUNK, 4, bits per ripple segment (one segment per pipeline stage); NSTAGES = WIDTH/CHUNK
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous, active-low reset (sampled on rising clk edge)
- in_valid  input  1  operands on A/B/Cin/sub are valid
- in_ready  output  1  block accepts operands this cycle
- A  input  WIDTH  operand A
- B  input  WIDTH  operand B
- Cin  input  1  carry-in (add mode only)
- sub  input  1  0: S = A + B + Cin; 1: S = A + ~B + 1 (Cin ignored)
- out_valid  output  1  result fields valid
- out_ready  input  1  downstream accepts result this cycle
- S  output  WIDTH  sum/difference
- Cout  output  1  carry out of MSB (subtract: 1 = no borrow)
- V  output  1  signed overflow = carry into MSB XOR carry out of MSB

## Operation
- One clock domain; reset synchronous, active-low, as decided.
- Elaboration error if WIDTH % CHUNK != 0 or CHUNK < 1.
- Subtract: effective B = ~B, effective carry-in = 1; decision latched with the operands, travels with them.
- Stage k (0..NSTAGES-1) ripples bits [k*CHUNK +: CHUNK] through CHUNK full-adder cells using the carry registered by stage k-1 (stage 0 uses effective carry-in); registers the completed low result bits, the chunk carry, and the still-unprocessed upper operand bits (skew registers).
- Last stage also registers Cout and V (V computed from carry into bit WIDTH-1 and carry out).
- Per-stage valid bit; data registers load only when the pipeline advances.
- Global advance: en = !out_valid || out_ready. in_ready = en. All stages shift together when en=1; none shift when en=0. Bubbles are not collapsed.
- Accept on in_valid && in_ready; result retired on out_valid && out_ready.
- Results emerge in acceptance order; no loss, no duplication.
- WIDTH == CHUNK: single stage, behaves as registered ripple adder.

## Timing
- Reset (rst_n=0 at edge): all stage valid bits 0, all data/carry registers 0; next cycle out_valid=0, S=0, Cout=0, V=0, in_ready=1.
- Latency: operation accepted at edge t appears with out_valid=1 after edge t+NSTAGES-1... i.e. visible in the cycle following edge t+NSTAGES-1 counting acceptance edge as stage-0 load; WIDTH=16/CHUNK=4: accepted at edge 0, out_valid high after edge 3 (4 register stages total, 4 cycles from in_valid assertion to out_valid).
- Throughput: 1 op/cycle while out_ready=1.
- Stall: out_valid=1 && out_ready=0 → in_ready=0 same cycle (combinational), all outputs held stable until retired.
- Simultaneous retire and accept in same cycle allowed (out_ready=1 frees pipe).
- in_valid=0 while en=1 inserts bubble (valid 0) that propagates.
- rst_n low mid-operation: all in-flight ops discarded at that edge; no partial result ever asserted.
- Outputs are register-driven except in_ready.

## Test plan
- Reset: hold rst_n=0 for 2 cycles with in_valid=1 → out_valid=0, S=0, Cout=0, V=0, in_ready=1; nothing emerges afterwards.
- Full carry chain: WIDTH=16, A=16'hFFFF, B=16'h0001, Cin=0, sub=0 → 4 cycles later S=16'h0000, Cout=1, V=0.
- Signed overflow: A=16'h7FFF, B=16'h0001, Cin=0 → S=16'h8000, Cout=0, V=1; A=16'h1234, B=16'h1111, Cin=1 → S=16'h2346, Cout=0, V=0.
- Subtract: sub=1, A=16'h0005, B=16'h0007, Cin=1 → S=16'hFFFE, Cout=0, V=0; sub=1, A=16'h8000, B=16'h0001 → S=16'h7FFF, Cout=1, V=1.
- Backpressure: 20 back-to-back random ops, out_ready pseudo-random → results match reference model in order, in_ready==!(out_valid&&!out_ready) every cycle, outputs stable while stalled.
- Reset mid-flight: 3 ops accepted, rst_n=0 one cycle → none of the 3 ever appear; subsequent op returns correct result at normal latency. Repeat with WIDTH=8, CHUNK=8 (latency 1) and WIDTH=32, CHUNK=8.
